tmds_channel_encoder: RTL and testbench
=======================================

# tmds_channel_encoder

Parametrised, pipelined TMDS encoder for one HDMI channel. It supports DVI video, control periods, video and data-island guard bands, and (optionally) HDMI TERC4 data-island symbols. It sits in the pixel-clock domain between the video/packet source and the 10:1 serializer. The three channels are built by instantiating it with CHANNEL = 0, 1 and 2 (blue, green, red).

## Interface
- CHANNEL, default 0: channel index 0..2. Selects the guard-band codes.
- DISP_W, default 6: width of the signed running-disparity register.
- clk  in  1: pixel clock. All registers are on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- ce  in  1: clock enable. When low, every register holds its value.
- mode  in  3: 0 CTRL, 1 VIDEO, 2 VGB (video guard), 3 DATA (TERC4), 4 DGB (data guard). Codes 5..7 are treated as CTRL.
- d_in  in  8: pixel component, used in VIDEO.
- ctrl  in  2: {c1,c0}, used in CTRL.
- aux  in  4: TERC4 nibble, used in DATA. Also used in DGB on CHANNEL 0.
- d_out  out  10: encoded symbol. Bit 0 is transmitted first.
- disp  out  DISP_W: signed running disparity after the current d_out. Provided for verification.

## Operation
- Stage 1, registered:
  - Compute the 9-bit q_m from d_in using the DVI 1.0 transition-minimisation rule: XNOR when N1(d_in)>4, or when N1==4 and d_in[0]==0.
  - Register q_m, N1(q_m[7:0]), mode, ctrl and aux.
- Stage 2, registered: select d_out by the stage-1 mode.
  - VIDEO: DVI 1.0 DC balance with cnt = disp. N1/N0 are counted over q_m[7:0].
    - If cnt==0 or N1==N0: d_out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
      - cnt += q_m8 ? (N1−N0) : (N0−N1).
    - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): d_out = {1, q_m8, ~q_m[7:0]}.
      - cnt += 2·q_m8 + (N0−N1).
    - Otherwise: d_out = {0, q_m8, q_m[7:0]}.
      - cnt += −2·(~q_m8) + (N1−N0).
  - CTRL: the ctrl codes are 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - VGB: CHANNEL 0 or 2 → 1011001100; CHANNEL 1 → 0100110011.
  - DGB:
    - CHANNEL 1 and 2 → 0100110011.
    - CHANNEL 0 → TERC4(aux). The source drives aux = {1,1,vsync,hsync}.
  - DATA: TERC4(aux), listed bit9..0 for aux 0..F:
    - 0–3: 1010011100, 1001100011, 1011100100, 1011100010
    - 4–7: 0101110001, 0100011110, 0110001110, 0100111100
    - 8–B: 1011001100, 0100111001, 0110011100, 1011000110
    - C–F: 1010001110, 1001110001, 0101100011, 1011000011
- disp is forced to 0 on every stage-2 update whose mode is not VIDEO.
- Arithmetic is signed DISP_W-bit. disp is always even, and its magnitude stays ≤ 10 for legal input, so DISP_W=6 never wraps.

## Timing
- Latency is 2 ce-qualified cycles, mode-for-mode, from input to d_out. All inputs, including mode, pass through the same pipeline, so there is no mode/data skew.
- The mode may change on any cycle; there is no handshake. The first VIDEO symbol after a non-VIDEO one starts from disp=0.
- ce low holds both stages and disp. The next ce-high cycle resumes exactly where it stopped.
- Reset, which takes effect immediately even mid-frame:
  - d_out = 1101010100 (CTRL 00) and disp = 0.
  - Stage-1 registers are set to mode CTRL, ctrl 00, q_m 0.
  - The first valid output appears 2 ce cycles after rst deasserts.
- rst has priority over ce.

## Configuration
- TMDS_TERC4_EN defined: DATA mode and the TERC4 path of DGB on CHANNEL 0 are implemented as above.
- TMDS_TERC4_EN undefined:
  - The TERC4 table is not built. DATA is encoded as CTRL with the registered ctrl.
  - DGB on CHANNEL 0 outputs the CTRL code for ctrl.
  - The resulting block is DVI-only.

## Test plan
- Reset, then ce=1, mode CTRL, ctrl 00..11 for 1 cycle each → from cycle 2: 1101010100, 0010101011, 0101010100, 1010101011; disp=0 throughout.
- Video d_in=0x00 continuously from disp=0 → d_out 0x100, 0x3FF, 0x100, 0x3FF…; disp −8, 2, −6, 4.
- Video 0x00 ×3, then CTRL, then video 0x00 → disp clears to 0 on the CTRL symbol; the next video symbol is 0x100 with disp −8.
- CHANNEL 1: VGB → 0100110011. CHANNEL 0: VGB → 1011001100. With TMDS_TERC4_EN: DATA aux=0x5 → 0100011110; CHANNEL 0 DGB aux=0xC → 1010001110.
- Video stream with ce toggling 1,0,1: d_out and disp hold through the low cycle, and the sequence matches the ce=1 reference.
- rst pulse mid-video (disp=2) → d_out=1101010100 and disp=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/tmds_channel_encoder_if.sv
// tmds_channel_encoder_if: source/encoder signal bundle for one TMDS channel
// master: ce, mode, d_in, ctrl, aux out; d_out, disp in (video/packet source side)
// slave : ce, mode, d_in, ctrl, aux in; d_out, disp out (encoder side)
interface tmds_channel_encoder_if #(parameter int DISP_W = 6);
  logic                     ce;
  logic [2:0]               mode;
  logic [7:0]               d_in;
  logic [1:0]               ctrl;
  logic [3:0]               aux;
  logic [9:0]               d_out;
  logic signed [DISP_W-1:0] disp;
  modport master(output ce, mode, d_in, ctrl, aux, input d_out, disp);
  modport slave(input ce, mode, d_in, ctrl, aux, output d_out, disp);
endinterface

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: two-stage TMDS encoder for one HDMI channel (video, control, guard bands, TERC4)
// clk, rst : pixel clock, asynchronous active-high reset
// bus      : slave modport; ce/mode/d_in/ctrl/aux in, d_out (bit 0 sent first) and running disparity out
// TMDS_TERC4_EN : when defined, builds the TERC4 table for DATA mode and the CHANNEL 0 data guard band
module tmds_channel_encoder #(
  parameter int CHANNEL = 0,
  parameter int DISP_W  = 6
) (
  input logic                   clk,
  input logic                   rst,
  tmds_channel_encoder_if.slave bus
);
  localparam logic [9:0] CTRL_CODE [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] VGB_CODE = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;
  localparam logic [9:0] DGB_CODE = 10'b0100110011;
  localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);
  localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);
`ifdef TMDS_TERC4_EN
  localparam logic [9:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  logic [3:0] r_aux;
`endif
  logic [3:0]               w_n1d;
  logic                     w_xnor;
  logic [8:0]               w_qm;
  logic [3:0]               w_n1q;
  logic [8:0]               r_qm;
  logic [3:0]               r_n1;
  logic [2:0]               r_mode;
  logic [1:0]               r_ctrl;
  logic [9:0]               r_dout;
  logic signed [DISP_W-1:0] r_disp;
  logic signed [DISP_W-1:0] w_diff;
  logic signed [DISP_W-1:0] w_vdisp;
  logic                     w_bal;
  logic                     w_inv;
  logic [9:0]               w_vid;
  logic [9:0]               w_ctl;
  logic [9:0]               w_dat;
  logic [9:0]               w_dgb;
  logic [9:0]               w_sym;
  logic signed [DISP_W-1:0] w_ndisp;
  // stage 1: transition-minimised q_m; xnor folds in as an xor with 1
  always_comb begin
    w_n1d = '0;
    for (int i = 0; i < 8; i++) w_n1d = w_n1d + {3'b0, bus.d_in[i]};
    w_xnor = (w_n1d > 4'd4) || (w_n1d == 4'd4 && !bus.d_in[0]);
    w_qm[0] = bus.d_in[0];
    for (int i = 1; i < 8; i++) w_qm[i] = w_qm[i-1] ^ bus.d_in[i] ^ w_xnor;
    w_qm[8] = ~w_xnor;
    w_n1q = '0;
    for (int i = 0; i < 8; i++) w_n1q = w_n1q + {3'b0, w_qm[i]};
  end
  // stage 2: DC balance, w_diff = N1 - N0 = 2*N1 - 8
  always_comb begin
    w_diff = DISP_W'({r_n1, 1'b0}) - EIGHT;
    w_bal = ~|r_disp || r_n1 == 4'd4;
    w_inv = (!r_disp[DISP_W-1] && r_n1 > 4'd4) || (r_disp[DISP_W-1] && r_n1 < 4'd4);
    w_vid = w_bal ? {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]} :
            w_inv ? {1'b1, r_qm[8], ~r_qm[7:0]} : {1'b0, r_qm[8], r_qm[7:0]};
    w_vdisp = r_disp + (w_bal ? (r_qm[8] ? w_diff : -w_diff) :
                        w_inv ? (r_qm[8] ? TWO : '0) - w_diff : w_diff - (r_qm[8] ? '0 : TWO));
    w_ctl = CTRL_CODE[r_ctrl];
`ifdef TMDS_TERC4_EN
    w_dat = TERC4[r_aux];
`else
    w_dat = w_ctl;
`endif
    w_dgb = (CHANNEL == 0) ? w_dat : DGB_CODE;
    w_sym = r_mode == 3'd1 ? w_vid : r_mode == 3'd2 ? VGB_CODE :
            r_mode == 3'd3 ? w_dat : r_mode == 3'd4 ? w_dgb : w_ctl;
    w_ndisp = r_mode == 3'd1 ? w_vdisp : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qm   <= '0;
      r_n1   <= '0;
      r_mode <= '0;
      r_ctrl <= '0;
`ifdef TMDS_TERC4_EN
      r_aux  <= '0;
`endif
      r_dout <= CTRL_CODE[0];
      r_disp <= '0;
    end else if (bus.ce) begin
      r_qm   <= w_qm;
      r_n1   <= w_n1q;
      r_mode <= bus.mode;
      r_ctrl <= bus.ctrl;
`ifdef TMDS_TERC4_EN
      r_aux  <= bus.aux;
`endif
      r_dout <= w_sym;
      r_disp <= w_ndisp;
    end
  end
  assign bus.d_out = r_dout;
  assign bus.disp  = r_disp;
endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder: scoreboard bench for CHANNEL 0 and CHANNEL 1 encoders against a spec-level model
module tb_tmds_channel_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tmds_channel_encoder_if #(.DISP_W(6)) b0();
  tmds_channel_encoder_if #(.DISP_W(6)) b1();
  assign b1.ce = b0.ce;
  assign b1.mode = b0.mode;
  assign b1.d_in = b0.d_in;
  assign b1.ctrl = b0.ctrl;
  assign b1.aux = b0.aux;
  tmds_channel_encoder #(.CHANNEL(0), .DISP_W(6)) u0(.clk(clk), .rst(rst), .bus(b0));
  tmds_channel_encoder #(.CHANNEL(1), .DISP_W(6)) u1(.clk(clk), .rst(rst), .bus(b1));
  typedef struct {logic [9:0] s0; logic [9:0] s1; int d;} exp_t;
  localparam logic [9:0] CTL [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
  exp_t q[$];
  exp_t last;
  int checks = 0;
  int passes = 0;
  int mdisp = 0;
  bit issued = 0;
  bit v1 = 0;
  bit v2 = 0;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a == e) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  task automatic video(input logic [7:0] d, output logic [9:0] s);
    int n1, n1q, n0q;
    bit xn, q8;
    logic [7:0] qm;
    n1 = $countones(d);
    xn = n1 > 4 || (n1 == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = !xn;
    n1q = $countones(qm);
    n0q = 8 - n1q;
    if (mdisp == 0 || n1q == n0q) begin
      s = {~q8, q8, q8 ? qm : ~qm};
      mdisp += q8 ? n1q - n0q : n0q - n1q;
    end else if ((mdisp > 0 && n1q > n0q) || (mdisp < 0 && n0q > n1q)) begin
      s = {1'b1, q8, ~qm};
      mdisp += 2 * int'(q8) + n0q - n1q;
    end else begin
      s = {1'b0, q8, qm};
      mdisp += -2 * int'(!q8) + n1q - n0q;
    end
  endtask

  function automatic logic [9:0] nonvid(input int ch, input logic [2:0] m, input logic [1:0] c, input logic [3:0] a);
    logic [9:0] t;
`ifdef TMDS_TERC4_EN
    t = TERC[a];
`else
    t = CTL[c];
`endif
    case (m)
      3'd2: return ch == 1 ? 10'b0100110011 : 10'b1011001100;
      3'd3: return t;
      3'd4: return ch == 0 ? t : 10'b0100110011;
      default: return CTL[c];
    endcase
  endfunction

  task automatic drive(input bit ce, input logic [2:0] m, input logic [7:0] d, input logic [1:0] c, input logic [3:0] a);
    exp_t e;
    logic [9:0] s;
    @(negedge clk);
    b0.ce = ce; b0.mode = m; b0.d_in = d; b0.ctrl = c; b0.aux = a;
    issued = ce;
    if (ce) begin
      if (m == 3'd1) begin
        video(d, s);
        e.s0 = s; e.s1 = s; e.d = mdisp;
      end else begin
        mdisp = 0;
        e.s0 = nonvid(0, m, c, a); e.s1 = nonvid(1, m, c, a); e.d = 0;
      end
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    b0.ce = 1'b0;
    issued = 0;
    rst = 1'b1;
    #1;
    chk("rst_dout0", int'(b0.d_out), int'(CTL[0]));
    chk("rst_dout1", int'(b1.d_out), int'(CTL[0]));
    chk("rst_disp", int'(b0.disp), 0);
    q.delete();
    v1 = 0; v2 = 0; mdisp = 0;
    last = '{CTL[0], CTL[0], 0};
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    bit c, iss;
    exp_t e;
    if (!rst) begin
      c = b0.ce;
      iss = issued;
      #1;
      if (c) begin
        v2 = v1;
        v1 = iss;
        if (v2) begin
          if (q.size() == 0) chk("underflow", 1, 0);
          else begin
            e = q.pop_front();
            last = e;
            chk("dout_ch0", int'(b0.d_out), int'(e.s0));
            chk("dout_ch1", int'(b1.d_out), int'(e.s1));
            chk("disp", int'(b0.disp), e.d);
          end
        end
      end else begin
        chk("hold_dout", int'(b0.d_out), int'(last.s0));
        chk("hold_disp", int'(b0.disp), last.d);
      end
    end
  end

  initial begin
    b0.ce = 0; b0.mode = 0; b0.d_in = 0; b0.ctrl = 0; b0.aux = 0;
    do_reset();
    for (int c = 0; c < 4; c++) drive(1, 3'd0, 8'h00, 2'(c), 4'h0);
    repeat (4) drive(1, 3'd1, 8'h00, 2'd0, 4'h0);
    drive(1, 3'd0, 8'h00, 2'd0, 4'h0);
    repeat (3) drive(1, 3'd1, 8'h00, 2'd0, 4'h0);
    drive(1, 3'd0, 8'h00, 2'd1, 4'h0);
    drive(1, 3'd1, 8'h00, 2'd0, 4'h0);
    drive(1, 3'd2, 8'h00, 2'd0, 4'h0);
    drive(1, 3'd4, 8'h00, 2'd2, 4'hC);
    drive(1, 3'd3, 8'h00, 2'd3, 4'h5);
    for (int a = 0; a < 16; a++) drive(1, 3'd3, 8'($urandom), 2'($urandom), 4'(a));
    for (int m = 5; m < 8; m++) drive(1, 3'(m), 8'($urandom), 2'($urandom), 4'($urandom));
    for (int i = 0; i < 6; i++) drive(i % 2 == 0, 3'd1, 8'($urandom), 2'd0, 4'h0);
    repeat (3) drive(1, 3'd1, 8'h00, 2'd0, 4'h0);
    do_reset();
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, ($urandom % 4 != 0) ? 3'd1 : 3'($urandom_range(0, 7)),
            8'($urandom), 2'($urandom), 4'($urandom));
    repeat (2) begin
      @(negedge clk);
      b0.ce = 1'b1; b0.mode = 3'd0; issued = 0;
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
